// File: rtl/usr_reg_pkg.sv
// Shared definitions for the USR_ACCESS user-word capture block.
// Holds the capture state encoding and the version-field bit positions.
`timescale 1ns/1ps
package usr_reg_pkg;

    typedef enum logic [1:0] {
        WAIT_VALID = 2'd0,
        SAMPLE     = 2'd1,
        DONE       = 2'd2,
        FAULT      = 2'd3
    } state_t;

    localparam int MAJOR_MSB = 31;
    localparam int MAJOR_LSB = 24;
    localparam int MINOR_MSB = 23;
    localparam int MINOR_LSB = 16;
    localparam int BUILD_MSB = 15;
    localparam int BUILD_LSB = 0;

endpackage

// File: rtl/usr_reg_sync.sv
// Parameterised single-bit synchroniser for asynchronous level signals.
// The flops are tagged so placement keeps the chain tight.
`timescale 1ns/1ps
module usr_reg_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/usr_reg_capture.sv
// Captures the bitstream user word once it has been stable for STABLE_COUNT
// samples after ConfigValid; faults if no capture lands within TIMEOUT_CYCLES.
`timescale 1ns/1ps
module usr_reg_capture
    import usr_reg_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_COUNT   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [31:0] Usr_Reg_Data,
    input  logic        ConfigValid,
    input  logic        Capture_Req,
    output logic [31:0] Captured_Data,
    output logic [7:0]  Version_Major,
    output logic [7:0]  Version_Minor,
    output logic [15:0] Build_Number,
    output logic        Data_Valid,
    output logic        Timeout,
    output logic        Busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    STB_LIMIT = 8'(STABLE_COUNT);

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TMO_LIMIT) ? v : v + 1'b1;
    endfunction

    state_t         r_state;
    logic [31:0]    r_held;
    logic [31:0]    r_captured;
    logic [7:0]     r_stab_cnt;
    logic [TW-1:0]  r_tmo_cnt;
    logic           r_data_valid;
    logic           r_timeout;
    logic           r_busy;

    logic           w_valid_s;
    logic           w_reload;
    logic [7:0]     w_stab_next;
    logic [TW-1:0]  w_tmo_next;
    logic           w_stab_done;
    logic           w_tmo_hit;

    usr_reg_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (aclk),
        .rst (reset),
        .i_d (ConfigValid),
        .o_q (w_valid_s)
    );

    // A zero count marks the first sample after entering SAMPLE.
    assign w_reload    = (r_stab_cnt == 8'd0) || (Usr_Reg_Data != r_held);
    assign w_stab_next = w_reload ? 8'd1 : r_stab_cnt + 8'd1;
    assign w_stab_done = w_valid_s && (w_stab_next == STB_LIMIT);
    assign w_tmo_next  = sat_inc(r_tmo_cnt);
    assign w_tmo_hit   = (w_tmo_next == TMO_LIMIT);

    // Held sample is pure data: the zero stability count forces a reload.
    always_ff @(posedge aclk) begin
        if (r_state == SAMPLE && w_valid_s && w_reload) begin
            r_held <= Usr_Reg_Data;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state      <= WAIT_VALID;
            r_captured   <= '0;
            r_stab_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_data_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            case (r_state)
                WAIT_VALID, SAMPLE: begin
                    r_tmo_cnt  <= w_tmo_next;
                    r_stab_cnt <= '0;
                    if (r_state == SAMPLE && w_valid_s) begin
                        r_stab_cnt <= w_stab_next;
                    end
                    // Completing the stability window beats the timeout.
                    if (r_state == SAMPLE && w_stab_done) begin
                        r_captured   <= Usr_Reg_Data;
                        r_data_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= DONE;
                    end else if (w_tmo_hit) begin
                        r_captured <= '0;
                        r_timeout  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= FAULT;
                    end else if (w_valid_s) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_state <= WAIT_VALID;
                    end
                end
                DONE, FAULT: begin
                    if (Capture_Req) begin
                        r_data_valid <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_stab_cnt   <= '0;
                        r_tmo_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= WAIT_VALID;
                    end
                end
                default: r_state <= WAIT_VALID;
            endcase
        end
    end

    assign Captured_Data = r_captured;
    assign Version_Major = r_captured[MAJOR_MSB:MAJOR_LSB];
    assign Version_Minor = r_captured[MINOR_MSB:MINOR_LSB];
    assign Build_Number  = r_captured[BUILD_MSB:BUILD_LSB];
    assign Data_Valid    = r_data_valid;
    assign Timeout       = r_timeout;
    assign Busy          = r_busy;

endmodule

// File: tb/tb_usr_reg_capture.sv
// Directed bench for usr_reg_capture: table of capture vectors plus
// hand-written restart, fault, reset and stability-window sequences.
`timescale 1ns/1ps
module tb_usr_reg_capture;

    localparam int SYNC_STAGES    = 2;
    localparam int STABLE_COUNT   = 4;
    localparam int TIMEOUT_CYCLES = 64;

    logic        aclk;
    logic        reset;
    logic [31:0] Usr_Reg_Data;
    logic        ConfigValid;
    logic        Capture_Req;
    logic [31:0] Captured_Data;
    logic [7:0]  Version_Major;
    logic [7:0]  Version_Minor;
    logic [15:0] Build_Number;
    logic        Data_Valid;
    logic        Timeout;
    logic        Busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    usr_reg_capture #(
        .SYNC_STAGES    (SYNC_STAGES),
        .STABLE_COUNT   (STABLE_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .aclk          (aclk),
        .reset         (reset),
        .Usr_Reg_Data  (Usr_Reg_Data),
        .ConfigValid   (ConfigValid),
        .Capture_Req   (Capture_Req),
        .Captured_Data (Captured_Data),
        .Version_Major (Version_Major),
        .Version_Minor (Version_Minor),
        .Build_Number  (Build_Number),
        .Data_Valid    (Data_Valid),
        .Timeout       (Timeout),
        .Busy          (Busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        int          cv_set;
        int          cap_edge;
        logic [7:0]  major;
        logic [7:0]  minor;
        logic [15:0] build;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ConfigValid = 1'b0;
        Capture_Req = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"},  Captured_Data, 32'h0);
        chk({tag, "_major"}, {24'h0, Version_Major}, 32'h0);
        chk({tag, "_minor"}, {24'h0, Version_Minor}, 32'h0);
        chk({tag, "_build"}, {16'h0, Build_Number}, 32'h0);
        chk({tag, "_dv"},    {31'h0, Data_Valid}, 32'h0);
        chk({tag, "_tmo"},   {31'h0, Timeout}, 32'h0);
        chk({tag, "_busy"},  {31'h0, Busy}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ConfigValid driven at cycle cv_set is first registered on edge cv_set+1;
        // capture lands SYNC_STAGES+STABLE_COUNT edges after that.
        vecs[0] = '{32'h0103_00A5,  9, 16, 8'h01, 8'h03, 16'h00A5};
        vecs[1] = '{32'h0204_0001,  0,  7, 8'h02, 8'h04, 16'h0001};
        vecs[2] = '{32'hFFFF_FFFF,  2,  9, 8'hFF, 8'hFF, 16'hFFFF};
        vecs[3] = '{32'h7E5A_C3F0, 57, 64, 8'h7E, 8'h5A, 16'hC3F0};

        Usr_Reg_Data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            Usr_Reg_Data = vecs[i].data;
            do_reset();
            if (i == 0) chk_reset_state("rst");
            while (cyc < vecs[i].cap_edge) begin
                if (cyc == vecs[i].cv_set) ConfigValid = 1'b1;
                step();
                if (cyc == vecs[i].cap_edge - 1) begin
                    chk("vec_dv_early",   {31'h0, Data_Valid}, 32'h0);
                    chk("vec_busy_early", {31'h0, Busy}, 32'h1);
                    chk("vec_tmo_early",  {31'h0, Timeout}, 32'h0);
                end
            end
            chk("vec_dv",    {31'h0, Data_Valid}, 32'h1);
            chk("vec_data",  Captured_Data, vecs[i].data);
            chk("vec_major", {24'h0, Version_Major}, {24'h0, vecs[i].major});
            chk("vec_minor", {24'h0, Version_Minor}, {24'h0, vecs[i].minor});
            chk("vec_build", {16'h0, Build_Number}, {16'h0, vecs[i].build});
            chk("vec_busy",  {31'h0, Busy}, 32'h0);
            chk("vec_tmo",   {31'h0, Timeout}, 32'h0);
        end

        // Data toggling during the first three SAMPLE edges delays capture by 3.
        Usr_Reg_Data = 32'h1111_1111;
        do_reset();
        while (cyc < 19) begin
            if (cyc == 9)  ConfigValid  = 1'b1;
            if (cyc == 12) Usr_Reg_Data = 32'h1111_1111;
            if (cyc == 13) Usr_Reg_Data = 32'h2222_2222;
            if (cyc == 14) Usr_Reg_Data = 32'h1111_1111;
            if (cyc == 15) Usr_Reg_Data = 32'h2222_2222;
            step();
            if (cyc == 18) chk("tog_dv_early", {31'h0, Data_Valid}, 32'h0);
        end
        chk("tog_dv",   {31'h0, Data_Valid}, 32'h1);
        chk("tog_data", Captured_Data, 32'h2222_2222);
        // Reset and Capture_Req together: reset clears the captured word too.
        reset       = 1'b1;
        Capture_Req = 1'b1;
        step();
        reset       = 1'b0;
        Capture_Req = 1'b0;
        chk_reset_state("rstreq");

        // Re-capture after DONE, then reset mid-SAMPLE.
        Usr_Reg_Data = 32'h0103_00A5;
        do_reset();
        while (cyc < 16) begin
            if (cyc == 9) ConfigValid = 1'b1;
            step();
        end
        chk("rc_first", Captured_Data, 32'h0103_00A5);
        Capture_Req = 1'b1;
        step();
        Capture_Req  = 1'b0;
        Usr_Reg_Data = 32'h0204_0001;
        chk("rc_dv_drop", {31'h0, Data_Valid}, 32'h0);
        chk("rc_hold",    Captured_Data, 32'h0103_00A5);
        chk("rc_busy",    {31'h0, Busy}, 32'h1);
        while (cyc < 21) step();
        chk("rc_dv_early", {31'h0, Data_Valid}, 32'h0);
        chk("rc_hold2",    Captured_Data, 32'h0103_00A5);
        step();
        chk("rc_dv",    {31'h0, Data_Valid}, 32'h1);
        chk("rc_data",  Captured_Data, 32'h0204_0001);
        chk("rc_major", {24'h0, Version_Major}, 32'h02);
        Capture_Req = 1'b1;
        step();
        Capture_Req = 1'b0;
        step();
        step();
        chk("mid_busy", {31'h0, Busy}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("midrst");

        // One-cycle ConfigValid drop mid-SAMPLE restarts the window.
        Usr_Reg_Data = 32'hA5A5_5A5A;
        do_reset();
        while (cyc < 20) begin
            if (cyc == 9)  ConfigValid = 1'b1;
            if (cyc == 12) ConfigValid = 1'b0;
            if (cyc == 13) ConfigValid = 1'b1;
            step();
            if (cyc == 19) chk("drop_dv_early", {31'h0, Data_Valid}, 32'h0);
        end
        chk("drop_dv",   {31'h0, Data_Valid}, 32'h1);
        chk("drop_data", Captured_Data, 32'hA5A5_5A5A);

        // ConfigValid never asserted: timeout exactly at edge 64, then restart.
        Usr_Reg_Data = 32'hDEAD_BEEF;
        do_reset();
        while (cyc < 64) begin
            step();
            if (cyc == 63) chk("tmo_early", {31'h0, Timeout}, 32'h0);
        end
        chk("tmo_flag", {31'h0, Timeout}, 32'h1);
        chk("tmo_busy", {31'h0, Busy}, 32'h0);
        chk("tmo_data", Captured_Data, 32'h0);
        chk("tmo_dv",   {31'h0, Data_Valid}, 32'h0);
        step();
        step();
        chk("tmo_hold", {31'h0, Timeout}, 32'h1);
        Capture_Req = 1'b1;
        ConfigValid = 1'b1;
        step();
        Capture_Req = 1'b0;
        chk("tmo_clr",  {31'h0, Timeout}, 32'h0);
        chk("tmo_rbusy", {31'h0, Busy}, 32'h1);
        while (cyc < 73) begin
            step();
            if (cyc == 72) chk("tmo_rc_early", {31'h0, Data_Valid}, 32'h0);
        end
        chk("tmo_rc_dv",   {31'h0, Data_Valid}, 32'h1);
        chk("tmo_rc_data", Captured_Data, 32'hDEAD_BEEF);

        // Periodic ConfigValid drops never allow a full window; the timeout
        // counter keeps running across the drops and fires at edge 64.
        do_reset();
        while (cyc < 64) begin
            ConfigValid = ((cyc % 5) != 4);
            step();
            if (cyc == 63) chk("per_tmo_early", {31'h0, Timeout}, 32'h0);
        end
        chk("per_tmo", {31'h0, Timeout}, 32'h1);
        chk("per_dv",  {31'h0, Data_Valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
